// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing constant sets and RGB packing helpers
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_800x600_72 = '{
    h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
    v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  // Framebuffer word layout is {b,g,r}, red in the low nibble.
  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb444_t;

  function automatic rgb444_t pack_rgb444(input logic [3:0] rr, input logic [3:0] gg,
                                          input logic [3:0] bb);
    return '{b: bb, g: gg, r: rr};
  endfunction

  function automatic logic in_window(input logic [31:0] val, input logic [31:0] lo,
                                     input logic [31:0] len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - ce-qualified shift register; DEPTH=0 is a plain wire
module vga_delay_line #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, ce, RST_VAL};
      assign q = d;
    end else begin : g_shift
      logic [W-1:0] stages [DEPTH];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
        end else if (ce) begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end
      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync generation and latency-matched RGB gating
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 11,
  parameter int PIX_LAT  = 1,
  parameter int COLOR_W  = 4,
  parameter int FRAME_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 req_active,
  input  logic [3*COLOR_W-1:0] pix_data,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic [FRAME_W-1:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last;
  logic             hs_raw, vs_raw;
  logic             dly_active, dly_hs, dly_vs;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        if (v_last) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Request stage is combinational so the memory address has no added latency.
  assign req_active  = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign x           = req_active ? h_cnt : '0;
  assign y           = req_active ? v_cnt : '0;
  assign frame_start = rst_n && ce && (h_cnt == '0) && (v_cnt == '0);

  assign hs_raw = in_window(32'(h_cnt), 32'(H_ACTIVE + H_FP), 32'(H_SYNC));
  assign vs_raw = in_window(32'(v_cnt), 32'(V_ACTIVE + V_FP), 32'(V_SYNC));

  vga_delay_line #(
    .W      (3),
    .DEPTH  (PIX_LAT),
    .RST_VAL(3'b000)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .d    ({req_active, hs_raw, vs_raw}),
    .q    ({dly_active, dly_hs, dly_vs})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (ce) begin
      {b, g, r} <= dly_active ? pix_data : '0;
      hsync     <= dly_hs ^ ~HS_POL;
      vsync     <= dly_vs ^ ~VS_POL;
    end
  end

endmodule
